// File: rtl/result_drain.sv
// Drains an N x N systolic array result one row per handshake from a shadow copy,
// then pulses array_clear and waits for array_ready to drop before re-arming.
module result_drain #(
    parameter int SYS_ARRAY_LEN = 4,
    parameter int DATA_W        = 32,
    parameter int CNT_W         = 16,
    localparam int N            = SYS_ARRAY_LEN,
    localparam int IDX_W        = (SYS_ARRAY_LEN > 1) ? $clog2(SYS_ARRAY_LEN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    array_ready,
    input  logic [N*N*DATA_W-1:0]   array_out,
    output logic                    array_clear,
    output logic [N*DATA_W-1:0]     row_data,
    output logic [IDX_W-1:0]        row_idx,
    output logic                    row_valid,
    input  logic                    row_ready,
    output logic                    row_last,
    output logic                    busy,
    output logic [CNT_W-1:0]        frame_count
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR,
        WAIT_LOW
    } state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [N*N*DATA_W-1:0]   r_shadow;
    logic [IDX_W-1:0]        r_ptr;
    logic [IDX_W-1:0]        w_ptrNext;
    logic [N*DATA_W-1:0]     r_rowData;
    logic [N*DATA_W-1:0]     w_rowDataNext;
    logic                    r_rowValid;
    logic                    w_rowValidNext;
    logic                    r_rowLast;
    logic                    w_rowLastNext;
    logic                    r_clear;
    logic                    w_clearNext;
    logic                    r_busy;
    logic [CNT_W-1:0]        r_count;
    logic [CNT_W-1:0]        w_countNext;
    logic                    w_capture;

    assign w_capture = (r_state == IDLE) && array_ready;

    // Row 0 is forwarded straight from array_out on capture so it appears with one cycle latency.
    always_comb begin
        w_stateNext    = r_state;
        w_ptrNext      = r_ptr;
        w_rowDataNext  = r_rowData;
        w_rowValidNext = r_rowValid;
        w_rowLastNext  = r_rowLast;
        w_countNext    = r_count;
        w_clearNext    = 1'b0;
        case (r_state)
            IDLE: begin
                if (array_ready) begin
                    w_stateNext    = DRAIN;
                    w_ptrNext      = '0;
                    w_rowDataNext  = array_out[N*DATA_W-1:0];
                    w_rowValidNext = 1'b1;
                    w_rowLastNext  = (N == 1);
                end
            end
            DRAIN: begin
                if (row_ready) begin
                    if (r_ptr == IDX_W'(N-1)) begin
                        w_stateNext    = CLEAR;
                        w_rowValidNext = 1'b0;
                        w_rowLastNext  = 1'b0;
                        w_countNext    = r_count + CNT_W'(1);
                        w_clearNext    = 1'b1;
                    end else begin
                        w_ptrNext      = r_ptr + IDX_W'(1);
                        w_rowDataNext  = r_shadow[int'(w_ptrNext)*N*DATA_W +: N*DATA_W];
                        w_rowLastNext  = (w_ptrNext == IDX_W'(N-1));
                    end
                end
            end
            CLEAR: begin
                w_stateNext = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!array_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_rowData  <= '0;
            r_rowValid <= 1'b0;
            r_rowLast  <= 1'b0;
            r_clear    <= 1'b0;
            r_busy     <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_ptr      <= w_ptrNext;
            r_rowData  <= w_rowDataNext;
            r_rowValid <= w_rowValidNext;
            r_rowLast  <= w_rowLastNext;
            r_clear    <= w_clearNext;
            r_busy     <= (w_stateNext != IDLE);
            r_count    <= w_countNext;
        end
    end

    // Shadow content is don't-care after reset, so it carries no reset term.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_shadow <= array_out;
        end
    end

    assign array_clear = r_clear;
    assign row_data    = r_rowData;
    assign row_idx     = r_ptr;
    assign row_valid   = r_rowValid;
    assign row_last    = r_rowLast;
    assign busy        = r_busy;
    assign frame_count = r_count;

endmodule

// File: tb/tb_result_drain.sv
// Randomised bench for result_drain: N=4 instance for draining/backpressure/reset,
// N=1 CNT_W=2 instance for single-row frames and counter wrap.
module tb_result_drain;

    localparam int N  = 4;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;

    logic              arrayReady = 1'b0;
    logic [N*N*DW-1:0] arrayOut   = '0;
    logic              arrayClear;
    logic [N*DW-1:0]   rowData;
    logic [1:0]        rowIdx;
    logic              rowValid;
    logic              rowReady   = 1'b0;
    logic              rowLast;
    logic              busy;
    logic [15:0]       frameCount;

    logic              bArrayReady = 1'b0;
    logic [DW-1:0]     bArrayOut   = '0;
    logic              bArrayClear;
    logic [DW-1:0]     bRowData;
    logic [0:0]        bRowIdx;
    logic              bRowValid;
    logic              bRowReady   = 1'b0;
    logic              bRowLast;
    logic              bBusy;
    logic [1:0]        bFrameCount;

    int                checks   = 0;
    int                failures = 0;
    int                expCount = 0;
    logic [DW-1:0]     mat [N][N];

    always #5 clk = ~clk;

    result_drain #(.SYS_ARRAY_LEN(N), .DATA_W(DW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .array_ready(arrayReady), .array_out(arrayOut),
        .array_clear(arrayClear), .row_data(rowData), .row_idx(rowIdx),
        .row_valid(rowValid), .row_ready(rowReady), .row_last(rowLast),
        .busy(busy), .frame_count(frameCount)
    );

    result_drain #(.SYS_ARRAY_LEN(1), .DATA_W(DW), .CNT_W(2)) dutOne (
        .clk(clk), .rst(rst), .array_ready(bArrayReady), .array_out(bArrayOut),
        .array_clear(bArrayClear), .row_data(bRowData), .row_idx(bRowIdx),
        .row_valid(bRowValid), .row_ready(bRowReady), .row_last(bRowLast),
        .busy(bBusy), .frame_count(bFrameCount)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] intToFloat(input int v);
        int e;
        logic [31:0] m;
        if (v == 0) return 32'h0;
        e = 0;
        while ((v >> (e + 1)) != 0) e++;
        m = (32'(v) << (23 - e)) & 32'h007F_FFFF;
        return {1'b0, 8'(e + 127), m[22:0]};
    endfunction

    function automatic logic [N*N*DW-1:0] packMat();
        logic [N*N*DW-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                p[(i*N+j)*DW +: DW] = mat[i][j];
        return p;
    endfunction

    function automatic logic [N*DW-1:0] expRow(input int r);
        logic [N*DW-1:0] row;
        row = '0;
        for (int j = 0; j < N; j++) row[j*DW +: DW] = mat[r][j];
        return row;
    endfunction

    task automatic randomMat();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                mat[i][j] = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({rowValid, rowLast, rowIdx, rowData, arrayClear, busy, frameCount} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_n4 got v=%b l=%b idx=%0d data=%h clr=%b busy=%b cnt=%0d expected all zero",
                     rowValid, rowLast, rowIdx, rowData, arrayClear, busy, frameCount);
        end
        checks++;
        if ({bRowValid, bRowLast, bRowIdx, bRowData, bArrayClear, bBusy, bFrameCount} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_n1 got v=%b l=%b data=%h clr=%b busy=%b cnt=%0d expected all zero",
                     bRowValid, bRowLast, bRowData, bArrayClear, bBusy, bFrameCount);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                mat[i][j] = 32'h4270_0000;
        arrayOut = packMat();
        arrayReady = 1'b1;
        rowReady = 1'b1;
        tick();
        arrayReady = 1'b0;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (rowValid !== 1'b1 || rowIdx !== 2'(k) || rowData !== expRow(k) ||
                rowLast !== (k == N-1) || arrayClear !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL basic_row k=%0d got v=%b idx=%0d l=%b clr=%b busy=%b data=%h expected v=1 idx=%0d l=%b clr=0 busy=1 data=%h",
                         k, rowValid, rowIdx, rowLast, arrayClear, busy, rowData, k, (k == N-1), expRow(k));
            end
            tick();
        end
        expCount++;
        checks++;
        if (rowValid !== 1'b0 || arrayClear !== 1'b1 || frameCount !== 16'(expCount)) begin
            failures++;
            $display("[TB] FAIL basic_clear got v=%b clr=%b cnt=%0d expected v=0 clr=1 cnt=%0d",
                     rowValid, arrayClear, frameCount, expCount);
        end
        tick();
        checks++;
        if (arrayClear !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_waitlow got clr=%b busy=%b expected clr=0 busy=1", arrayClear, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_idle got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_backpressure();
        int            xfers;
        bit            done;
        bit            prevStall;
        logic [N*DW-1:0] prevData;
        logic [1:0]    prevIdx;
        bit            pattern [6];
        pattern = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        randomMat();
        arrayOut = packMat();
        arrayReady = 1'b1;
        rowReady = 1'b0;
        tick();
        arrayReady = 1'b0;
        arrayOut = ~arrayOut;
        xfers = 0;
        done = 1'b0;
        prevStall = 1'b0;
        prevData = '0;
        prevIdx = '0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            if (arrayClear === 1'b1) begin
                done = 1'b1;
            end else if (rowValid === 1'b1) begin
                if (prevStall) begin
                    checks++;
                    if (rowData !== prevData || rowIdx !== prevIdx) begin
                        failures++;
                        $display("[TB] FAIL bp_stable cyc=%0d got idx=%0d data=%h expected idx=%0d data=%h",
                                 cyc, rowIdx, rowData, prevIdx, prevData);
                    end
                end
                checks++;
                if (xfers >= N || rowIdx !== 2'(xfers) || rowData !== expRow(xfers % N)) begin
                    failures++;
                    $display("[TB] FAIL bp_order cyc=%0d got idx=%0d data=%h expected idx=%0d data=%h",
                             cyc, rowIdx, rowData, xfers, expRow(xfers % N));
                end
            end
            rowReady = (cyc < 6) ? pattern[cyc] : 1'($urandom_range(0, 1));
            if (rowValid === 1'b1 && rowReady) xfers++;
            prevStall = (rowValid === 1'b1) && !rowReady;
            prevData = rowData;
            prevIdx = rowIdx;
            if (!done) tick();
        end
        expCount++;
        checks++;
        if (!done || xfers != N || frameCount !== 16'(expCount)) begin
            failures++;
            $display("[TB] FAIL bp_total got done=%0d xfers=%0d cnt=%0d expected done=1 xfers=%0d cnt=%0d",
                     done, xfers, frameCount, N, expCount);
        end
        rowReady = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_shadow();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                mat[i][j] = intToFloat(i*N + j);
        arrayOut = packMat();
        arrayReady = 1'b1;
        rowReady = 1'b1;
        tick();
        arrayOut = '0;
        arrayReady = 1'b0;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (rowValid !== 1'b1 || rowIdx !== 2'(k) || rowData !== expRow(k)) begin
                failures++;
                $display("[TB] FAIL shadow_row k=%0d got v=%b idx=%0d data=%h expected v=1 idx=%0d data=%h",
                         k, rowValid, rowIdx, rowData, k, expRow(k));
            end
            tick();
        end
        expCount++;
        checks++;
        if (arrayClear !== 1'b1 || frameCount !== 16'(expCount)) begin
            failures++;
            $display("[TB] FAIL shadow_clear got clr=%b cnt=%0d expected clr=1 cnt=%0d", arrayClear, frameCount, expCount);
        end
        tick();
        tick();
    endtask

    task automatic test_hold_ready();
        randomMat();
        arrayOut = packMat();
        arrayReady = 1'b1;
        rowReady = 1'b1;
        tick();
        arrayOut = ~arrayOut;
        for (int k = 0; k < N; k++) tick();
        expCount++;
        checks++;
        if (arrayClear !== 1'b1 || frameCount !== 16'(expCount)) begin
            failures++;
            $display("[TB] FAIL hold_clear got clr=%b cnt=%0d expected clr=1 cnt=%0d", arrayClear, frameCount, expCount);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (rowValid !== 1'b0 || busy !== 1'b1 || arrayClear !== 1'b0 || frameCount !== 16'(expCount)) begin
                failures++;
                $display("[TB] FAIL hold_waitlow c=%0d got v=%b busy=%b clr=%b cnt=%0d expected v=0 busy=1 clr=0 cnt=%0d",
                         c, rowValid, busy, arrayClear, frameCount, expCount);
            end
        end
        arrayReady = 1'b0;
        randomMat();
        arrayOut = packMat();
        tick();
        checks++;
        if (busy !== 1'b0 || rowValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hold_idle got busy=%b v=%b expected busy=0 v=0", busy, rowValid);
        end
        arrayReady = 1'b1;
        tick();
        arrayReady = 1'b0;
        checks++;
        if (rowValid !== 1'b1 || rowIdx !== 2'd0 || rowData !== expRow(0)) begin
            failures++;
            $display("[TB] FAIL hold_recapture got v=%b idx=%0d data=%h expected v=1 idx=0 data=%h",
                     rowValid, rowIdx, rowData, expRow(0));
        end
        for (int k = 0; k < N; k++) tick();
        expCount++;
        checks++;
        if (frameCount !== 16'(expCount)) begin
            failures++;
            $display("[TB] FAIL hold_count got %0d expected %0d", frameCount, expCount);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        randomMat();
        arrayOut = packMat();
        arrayReady = 1'b1;
        rowReady = 1'b1;
        tick();
        arrayReady = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        expCount = 0;
        checks++;
        if ({rowValid, rowLast, rowIdx, rowData, arrayClear, busy, frameCount} !== '0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs got v=%b l=%b idx=%0d data=%h clr=%b busy=%b cnt=%0d expected all zero",
                     rowValid, rowLast, rowIdx, rowData, arrayClear, busy, frameCount);
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (arrayClear !== 1'b0 || frameCount !== 16'd0 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL midreset_quiet c=%0d got clr=%b cnt=%0d busy=%b expected clr=0 cnt=0 busy=0",
                         c, arrayClear, frameCount, busy);
            end
        end
        randomMat();
        arrayOut = packMat();
        arrayReady = 1'b1;
        tick();
        arrayReady = 1'b0;
        checks++;
        if (rowValid !== 1'b1 || rowIdx !== 2'd0 || rowData !== expRow(0)) begin
            failures++;
            $display("[TB] FAIL midreset_fresh got v=%b idx=%0d data=%h expected v=1 idx=0 data=%h",
                     rowValid, rowIdx, rowData, expRow(0));
        end
        for (int k = 0; k < N; k++) tick();
        expCount++;
        checks++;
        if (arrayClear !== 1'b1 || frameCount !== 16'(expCount)) begin
            failures++;
            $display("[TB] FAIL midreset_drain got clr=%b cnt=%0d expected clr=1 cnt=%0d", arrayClear, frameCount, expCount);
        end
        tick();
        tick();
    endtask

    task automatic test_n1_wrap();
        logic [DW-1:0] d;
        for (int f = 1; f <= 4; f++) begin
            d = $urandom;
            bArrayOut = d;
            bArrayReady = 1'b1;
            bRowReady = 1'b0;
            tick();
            bArrayReady = 1'b0;
            bArrayOut = ~d;
            tick();
            checks++;
            if (bRowValid !== 1'b1 || bRowLast !== 1'b1 || bRowIdx !== 1'b0 || bRowData !== d) begin
                failures++;
                $display("[TB] FAIL n1_row f=%0d got v=%b l=%b idx=%0d data=%h expected v=1 l=1 idx=0 data=%h",
                         f, bRowValid, bRowLast, bRowIdx, bRowData, d);
            end
            bRowReady = 1'b1;
            tick();
            checks++;
            if (bRowValid !== 1'b0 || bArrayClear !== 1'b1 || bFrameCount !== 2'(f % 4)) begin
                failures++;
                $display("[TB] FAIL n1_clear f=%0d got v=%b clr=%b cnt=%0d expected v=0 clr=1 cnt=%0d",
                         f, bRowValid, bArrayClear, bFrameCount, f % 4);
            end
            bRowReady = 1'b0;
            tick();
            tick();
            checks++;
            if (bBusy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL n1_idle f=%0d got busy=%b expected 0", f, bBusy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_shadow();
        test_hold_ready();
        test_reset_mid();
        test_n1_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
